// File: rtl/mshr_ctrl_pkg.sv
// Shared cache package for the MSHR controller.
// Holds the per-entry state encoding and the default geometry.
package mshr_ctrl_pkg;

  typedef enum logic [1:0] {
    E_FREE = 2'd0,
    E_PEND = 2'd1,
    E_WAIT = 2'd2,
    E_DONE = 2'd3
  } ent_state_e;

  localparam int MSHR_N_ENTRIES = 8;
  localparam int MSHR_LINE_BITS = 28;

endpackage

// File: rtl/mshr_ctrl_rr_pick.sv
// Round-robin first-set search.
// Ports:
//   req_i  - request vector, one bit per entry
//   ptr_i  - index where the search starts
//   any_o  - at least one request bit is set
//   idx_o  - first set index at or after ptr_i, wrapping; 0 when none set
module rr_pick #(
  parameter int N        = 8,
  parameter int IDX_BITS = 3
) (
  input  logic [N-1:0]        req_i,
  input  logic [IDX_BITS-1:0] ptr_i,
  output logic                any_o,
  output logic [IDX_BITS-1:0] idx_o
);

  int pos;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    pos   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = (int'(ptr_i) + k) % N;
      if (req_i[pos]) begin
        any_o = 1'b1;
        idx_o = IDX_BITS'(pos);
      end
    end
  end

endmodule

// File: rtl/mshr_ctrl.sv
// Miss status holding register controller.
// Tracks outstanding cache-line misses through FREE -> PEND -> WAIT -> DONE -> FREE.
// Optional feature macro: MSHR_MERGE_EN (merge a miss into a live entry with the same line).
// Ports:
//   clk, rst                 - clock, synchronous active-low reset
//   miss_valid, miss_line    - miss allocation request
//   mshr_wr_idx, mshr_full   - index the current miss uses, no free entry
//   miss_merged              - current miss hit a PEND/WAIT entry (merge build only)
//   mem_req_*                - memory request valid/ready handshake with line and index
//   mem_resp_valid/idx       - fill return
//   mshr_fin, mshr_fin_idx   - registered one-cycle completion pulse
//   resp_err                 - sticky: fill arrived for an entry not in WAIT
//
// state  | meaning
// FREE   | entry unused, may be allocated
// PEND   | miss captured, memory request not yet accepted
// WAIT   | request accepted, waiting for fill
// DONE   | fill seen, completion pulse this cycle, frees on next edge
module mshr_ctrl
  import mshr_ctrl_pkg::*;
#(
  parameter int N_ENTRIES = MSHR_N_ENTRIES,
  parameter int IDX_BITS  = 3,
  parameter int LINE_BITS = MSHR_LINE_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_valid,
  input  logic [LINE_BITS-1:0] miss_line,
  output logic [IDX_BITS-1:0]  mshr_wr_idx,
  output logic                 mshr_full,
  output logic                 miss_merged,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [LINE_BITS-1:0] mem_req_line,
  output logic [IDX_BITS-1:0]  mem_req_idx,
  input  logic                 mem_resp_valid,
  input  logic [IDX_BITS-1:0]  mem_resp_idx,
  output logic                 mshr_fin,
  output logic [IDX_BITS-1:0]  mshr_fin_idx,
  output logic                 resp_err
);

  ent_state_e           state_q [N_ENTRIES];
  ent_state_e           state_d [N_ENTRIES];
  logic [LINE_BITS-1:0] line_q  [N_ENTRIES];
  logic [LINE_BITS-1:0] line_d  [N_ENTRIES];

  logic [IDX_BITS-1:0]  rr_ptr_q, rr_ptr_d;
  logic                 lock_q, lock_d;
  logic [IDX_BITS-1:0]  lock_idx_q, lock_idx_d;
  logic                 fin_q, fin_d;
  logic [IDX_BITS-1:0]  fin_idx_q, fin_idx_d;
  logic                 err_q, err_d;
  logic                 post_rst_q;

  logic [N_ENTRIES-1:0] pend_vec;
  logic                 pick_any;
  logic [IDX_BITS-1:0]  pick_idx;
  logic [IDX_BITS-1:0]  issue_idx;
  logic [IDX_BITS-1:0]  free_idx;
  logic                 free_any;
  logic                 alloc;
  logic                 handshake;
  logic                 fill_ok;

  always_comb begin
    pend_vec = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      pend_vec[i] = (state_q[i] == E_PEND);
      if (state_q[i] == E_FREE) begin
        free_any = 1'b1;
        free_idx = IDX_BITS'(i);
      end
    end
  end

  assign mshr_full = ~free_any;

`ifdef MSHR_MERGE_EN
  logic                hit;
  logic [IDX_BITS-1:0] hit_idx;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if ((state_q[i] == E_PEND || state_q[i] == E_WAIT) && line_q[i] == miss_line) begin
        hit     = 1'b1;
        hit_idx = IDX_BITS'(i);
      end
    end
  end

  assign miss_merged = miss_valid & hit;
  assign mshr_wr_idx = miss_merged ? hit_idx : free_idx;
`else
  assign miss_merged = 1'b0;
  assign mshr_wr_idx = free_idx;
`endif

  rr_pick #(
    .N        (N_ENTRIES),
    .IDX_BITS (IDX_BITS)
  ) u_rr_pick (
    .req_i (pend_vec),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  // Once a request stalls, keep presenting the same entry even if a newer
  // PEND entry lands between rr_ptr and it.
  assign issue_idx     = lock_q ? lock_idx_q : pick_idx;
  assign mem_req_valid = pick_any;
  assign mem_req_idx   = issue_idx;
  assign mem_req_line  = line_q[issue_idx];

  assign handshake = mem_req_valid & mem_req_ready;
  assign alloc     = miss_valid & ~mshr_full & ~miss_merged;
  // Fills right after reset belong to discarded requests and are dropped silently.
  assign fill_ok   = mem_resp_valid & ~post_rst_q & (state_q[mem_resp_idx] == E_WAIT);

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (state_q[i] == E_DONE) state_d[i] = E_FREE;
    end
    if (alloc) begin
      state_d[free_idx] = E_PEND;
      line_d[free_idx]  = miss_line;
    end
    if (handshake) state_d[issue_idx] = E_WAIT;
    if (fill_ok) state_d[mem_resp_idx] = E_DONE;

    rr_ptr_d = rr_ptr_q;
    if (handshake) begin
      rr_ptr_d = (int'(issue_idx) == N_ENTRIES - 1) ? '0 : issue_idx + 1'b1;
    end
    lock_d     = mem_req_valid & ~mem_req_ready;
    lock_idx_d = issue_idx;

    fin_d     = fill_ok;
    fin_idx_d = fill_ok ? mem_resp_idx : '0;
    err_d     = err_q | (mem_resp_valid & ~fill_ok & ~post_rst_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        state_q[i] <= E_FREE;
        line_q[i]  <= '0;
      end
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      fin_q      <= 1'b0;
      fin_idx_q  <= '0;
      err_q      <= 1'b0;
      post_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      fin_q      <= fin_d;
      fin_idx_q  <= fin_idx_d;
      err_q      <= err_d;
      post_rst_q <= 1'b0;
    end
  end

  assign mshr_fin     = fin_q;
  assign mshr_fin_idx = fin_idx_q;
  assign resp_err     = err_q;

endmodule

// File: tb/tb_mshr_ctrl.sv
module tb_mshr_ctrl;

  typedef struct {
    logic [2:0]  idx;
    logic [27:0] line;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss_valid = 1'b0;
  logic [27:0] miss_line = '0;
  logic [2:0]  mshr_wr_idx;
  logic        mshr_full;
  logic        miss_merged;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [27:0] mem_req_line;
  logic [2:0]  mem_req_idx;
  logic        mem_resp_valid = 1'b0;
  logic [2:0]  mem_resp_idx = '0;
  logic        mshr_fin;
  logic [2:0]  mshr_fin_idx;
  logic        resp_err;

  int   total = 0;
  int   bad = 0;
  logic mon_en = 1'b0;
  req_t exp_req[$];
  int   exp_fin[$];

  always #5 clk = ~clk;

  mshr_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .miss_valid     (miss_valid),
    .miss_line      (miss_line),
    .mshr_wr_idx    (mshr_wr_idx),
    .mshr_full      (mshr_full),
    .miss_merged    (miss_merged),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_line   (mem_req_line),
    .mem_req_idx    (mem_req_idx),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_idx   (mem_resp_idx),
    .mshr_fin       (mshr_fin),
    .mshr_fin_idx   (mshr_fin_idx),
    .resp_err       (resp_err)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a handshake or a fin pulse.
  logic       prev_stall = 1'b0;
  logic [2:0] prev_idx = '0;
  logic [27:0] prev_line = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst) begin
        if (mem_req_valid) begin
          if (prev_stall) begin
            check("req_idx_stable", 64'(mem_req_idx), 64'(prev_idx));
            check("req_line_stable", 64'(mem_req_line), 64'(prev_line));
          end
          if (mem_req_ready) begin
            if (exp_req.size() == 0) begin
              total++;
              bad++;
              $display("FAIL req_unexpected: got idx %0d, no request expected", mem_req_idx);
            end else begin
              req_t e;
              e = exp_req.pop_front();
              check("req_idx", 64'(mem_req_idx), 64'(e.idx));
              check("req_line", 64'(mem_req_line), 64'(e.line));
            end
          end
          prev_stall = ~mem_req_ready;
          prev_idx   = mem_req_idx;
          prev_line  = mem_req_line;
        end else begin
          prev_stall = 1'b0;
        end
        if (mshr_fin) begin
          if (exp_fin.size() == 0) begin
            total++;
            bad++;
            $display("FAIL fin_unexpected: got fin idx %0d, no fin expected", mshr_fin_idx);
          end else begin
            check("fin_idx", 64'(mshr_fin_idx), 64'(exp_fin.pop_front()));
          end
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    settle();
    check("rst_full", 64'(mshr_full), 64'(0));
    check("rst_wr_idx", 64'(mshr_wr_idx), 64'(0));
    check("rst_req_valid", 64'(mem_req_valid), 64'(0));
    check("rst_fin", 64'(mshr_fin), 64'(0));
    check("rst_fin_idx", 64'(mshr_fin_idx), 64'(0));
    check("rst_err", 64'(resp_err), 64'(0));
    mon_en = 1'b1;

    // Fill case: line 0x1234567, ready held, fill three cycles after the miss
    mem_req_ready = 1'b1;
    miss_valid = 1'b1;
    miss_line  = 28'h1234567;
    exp_req.push_back('{idx: 3'd0, line: 28'h1234567});
    tick();
    miss_valid = 1'b0;
    settle();
    check("a_req_valid", 64'(mem_req_valid), 64'(1));
    check("a_req_idx", 64'(mem_req_idx), 64'(0));
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_idx   = 3'd0;
    exp_fin.push_back(0);
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check("a_fin", 64'(mshr_fin), 64'(1));
    check("a_wr_idx_busy", 64'(mshr_wr_idx), 64'(1));
    tick();
    settle();
    check("a_fin_off", 64'(mshr_fin), 64'(0));
    check("a_wr_idx_free", 64'(mshr_wr_idx), 64'(0));

    // Error case: fill to FREE entry 4
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_idx   = 3'd4;
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check("e_err", 64'(resp_err), 64'(1));
    check("e_no_fin", 64'(mshr_fin), 64'(0));
    tick();
    settle();
    check("e_err_sticky", 64'(resp_err), 64'(1));
    do_reset();
    settle();
    check("e_err_cleared", 64'(resp_err), 64'(0));

    // Full case: 8 misses, 9th dropped, fill 5 frees idx 5 two cycles later
    for (int i = 0; i < 8; i++) begin
      miss_valid = 1'b1;
      miss_line  = 28'h100 + 28'(i);
      settle();
      check("f_wr_idx", 64'(mshr_wr_idx), 64'(i));
      tick();
    end
    miss_valid = 1'b0;
    settle();
    check("f_full", 64'(mshr_full), 64'(1));
    check("f_full_wr_idx", 64'(mshr_wr_idx), 64'(0));
    miss_valid = 1'b1;
    miss_line  = 28'h999;
    tick();
    miss_valid = 1'b0;
    settle();
    check("f_full_after9", 64'(mshr_full), 64'(1));
    for (int i = 0; i < 8; i++) exp_req.push_back('{idx: 3'(i), line: 28'h100 + 28'(i)});
    mem_req_ready = 1'b1;
    repeat (8) tick();
    mem_req_ready = 1'b0;
    settle();
    check("f_no_9th_req", 64'(mem_req_valid), 64'(0));
    mem_resp_valid = 1'b1;
    mem_resp_idx   = 3'd5;
    exp_fin.push_back(5);
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check("f_full_done", 64'(mshr_full), 64'(1));
    tick();
    settle();
    check("f_not_full", 64'(mshr_full), 64'(0));
    check("f_wr_idx5", 64'(mshr_wr_idx), 64'(5));
    do_reset();

    // Backpressure case: set up 2,3,6 PEND with rr_ptr at 7
    for (int i = 0; i < 7; i++) begin
      miss_valid = 1'b1;
      miss_line  = 28'h300 + 28'(i);
      tick();
    end
    miss_valid = 1'b0;
    for (int i = 0; i < 7; i++) exp_req.push_back('{idx: 3'(i), line: 28'h300 + 28'(i)});
    mem_req_ready = 1'b1;
    repeat (7) tick();
    mem_req_ready = 1'b0;
    foreach (exp_fin[i]) ;
    mem_resp_valid = 1'b1;
    mem_resp_idx = 3'd2; exp_fin.push_back(2); tick();
    mem_resp_idx = 3'd3; exp_fin.push_back(3); tick();
    mem_resp_idx = 3'd6; exp_fin.push_back(6); tick();
    mem_resp_valid = 1'b0;
    tick();
    tick();
    settle();
    check("b_wr_idx2", 64'(mshr_wr_idx), 64'(2));
    miss_valid = 1'b1;
    miss_line = 28'h402; tick();
    miss_line = 28'h403; tick();
    miss_line = 28'h406; tick();
    miss_valid = 1'b0;
    exp_req.push_back('{idx: 3'd2, line: 28'h402});
    exp_req.push_back('{idx: 3'd3, line: 28'h403});
    exp_req.push_back('{idx: 3'd6, line: 28'h406});
    exp_req.push_back('{idx: 3'd7, line: 28'h407});
    settle();
    check("b_stall_idx", 64'(mem_req_idx), 64'(2));
    tick();
    miss_valid = 1'b1;
    miss_line  = 28'h407;
    settle();
    check("b_wr_idx7", 64'(mshr_wr_idx), 64'(7));
    tick();
    miss_valid = 1'b0;
    settle();
    check("b_stall_idx_after_alloc", 64'(mem_req_idx), 64'(2));
    check("b_stall_line", 64'(mem_req_line), 64'(28'h402));
    tick();
    tick();
    mem_req_ready = 1'b1;
    repeat (4) tick();
    mem_req_ready = 1'b0;
    settle();
    check("b_drained", 64'(mem_req_valid), 64'(0));

    // Reset case: entries 0 and 1 in WAIT, then reset
    do_reset();
    exp_req.push_back('{idx: 3'd0, line: 28'h500});
    exp_req.push_back('{idx: 3'd1, line: 28'h501});
    mem_req_ready = 1'b1;
    miss_valid = 1'b1;
    miss_line = 28'h500; tick();
    miss_line = 28'h501; tick();
    miss_valid = 1'b0;
    tick();
    mem_req_ready = 1'b0;
    settle();
    check("r_pre_wr_idx", 64'(mshr_wr_idx), 64'(2));
    rst = 1'b0;
    tick();
    settle();
    check("r_wr_idx", 64'(mshr_wr_idx), 64'(0));
    check("r_full", 64'(mshr_full), 64'(0));
    check("r_req_valid", 64'(mem_req_valid), 64'(0));
    check("r_fin", 64'(mshr_fin), 64'(0));
    rst = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_idx   = 3'd0;
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check("r_first_fill_err", 64'(resp_err), 64'(0));
    check("r_first_fill_fin", 64'(mshr_fin), 64'(0));
    mem_resp_valid = 1'b1;
    mem_resp_idx   = 3'd1;
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check("r_wait_discarded", 64'(resp_err), 64'(1));
    check("r_no_fin", 64'(mshr_fin), 64'(0));
    do_reset();

    // Merge case: second miss to the line held by WAIT entry 1
    miss_valid = 1'b1;
    miss_line = 28'hAAA; tick();
    miss_line = 28'hBBB; tick();
    miss_valid = 1'b0;
    exp_req.push_back('{idx: 3'd0, line: 28'hAAA});
    exp_req.push_back('{idx: 3'd1, line: 28'hBBB});
    mem_req_ready = 1'b1;
    tick();
    tick();
    mem_req_ready = 1'b0;
    miss_valid = 1'b1;
    miss_line  = 28'hBBB;
    settle();
`ifdef MSHR_MERGE_EN
    check("m_merged", 64'(miss_merged), 64'(1));
    check("m_wr_idx", 64'(mshr_wr_idx), 64'(1));
    tick();
    miss_valid = 1'b0;
    settle();
    check("m_no_alloc_idx", 64'(mshr_wr_idx), 64'(2));
    check("m_no_alloc_req", 64'(mem_req_valid), 64'(0));
`else
    check("m_not_merged", 64'(miss_merged), 64'(0));
    check("m_wr_idx_new", 64'(mshr_wr_idx), 64'(2));
    miss_valid = 1'b0;
`endif

    repeat (3) tick();
    check("end_req_queue", 64'(exp_req.size()), 64'(0));
    check("end_fin_queue", 64'(exp_fin.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mshr_ctrl.md
MSHR_CTRL -- requirements
Module: mshr_ctrl

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 8: number of MSHR entries.
REQ-002 SHALL have parameter IDX_BITS, default 3: entry index width, equal to log2(N_ENTRIES).
REQ-003 SHALL have parameter LINE_BITS, default 28: cache-line address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port miss_valid, input, 1 bit: cache miss allocation request.
REQ-007 SHALL have port miss_line, input, LINE_BITS: line address of the miss.
REQ-008 SHALL have port mshr_wr_idx, output, IDX_BITS: index the current miss will use.
REQ-009 SHALL have port mshr_full, output, 1 bit: no FREE entry is available.
REQ-010 SHALL have port miss_merged, output, 1 bit: the current miss matched a live entry.
REQ-011 SHALL have port mem_req_valid, output, 1 bit: memory request handshake valid.
REQ-012 SHALL have port mem_req_ready, input, 1 bit: memory request handshake ready.
REQ-013 SHALL have port mem_req_line, output, LINE_BITS: line address of the request.
REQ-014 SHALL have port mem_req_idx, output, IDX_BITS: entry index of the request.
REQ-015 SHALL have port mem_resp_valid, input, 1 bit: fill return.
REQ-016 SHALL have port mem_resp_idx, input, IDX_BITS: entry index of the fill.
REQ-017 SHALL have port mshr_fin, output, 1 bit: one-cycle completion pulse.
REQ-018 SHALL have port mshr_fin_idx, output, IDX_BITS: index of the completing entry.
REQ-019 SHALL have port resp_err, output, 1 bit: sticky flag for a fill to a non-WAIT entry.

Function
REQ-020 Each entry SHALL hold a state in {FREE, PEND, WAIT, DONE} plus a LINE_BITS address.
REQ-021 mshr_wr_idx and mshr_full SHALL be combinational from registered state.
- mshr_wr_idx is the lowest-index FREE entry; 0 when full.
- mshr_full is 1 when no entry is FREE.
REQ-022 When miss_valid=1, mshr_full=0 and the miss is not merged, the selected entry SHALL go FREE->PEND at the clock edge and capture miss_line; when full, the miss SHALL be dropped and the requester holds.
REQ-023 mem_req_valid SHALL be 1 when any entry is PEND.
- The presented entry is the first PEND at or after rr_ptr, searching round-robin.
- mem_req_line and mem_req_idx SHALL stay stable while valid=1 and ready=0.
REQ-024 On mem_req_valid && mem_req_ready, the presented entry SHALL go PEND->WAIT and rr_ptr SHALL become its index+1, modulo N_ENTRIES.
REQ-025 A miss allocated at edge N SHALL reach mem_req_valid no earlier than cycle N+1; this is 1-cycle minimum latency.
REQ-026 For a fill arriving while the addressed entry is in WAIT:
- When mem_resp_valid=1 at edge N, that entry SHALL go WAIT->DONE.
- mshr_fin=1 and mshr_fin_idx SHALL be registered outputs valid during cycle N+1.
- The entry SHALL go DONE->FREE at edge N+1.
REQ-027 A freed index SHALL NOT appear on mshr_wr_idx until cycle N+2, so a fin index never aliases a same-cycle allocation.
REQ-028 A fill to an entry not in WAIT SHALL be ignored and SHALL set resp_err, which holds until reset.
REQ-029 Allocation, issue and fill occurring in the same cycle on distinct entries SHALL all take effect independently.
REQ-030 At most one fill per cycle is accepted, so at most one DONE entry exists at any time.

Reset
REQ-031 On the first edge with rst=0, the block SHALL reset to:
- all entries FREE and rr_ptr=0;
- mshr_fin=0, mshr_fin_idx=0 and resp_err=0.
REQ-032 Reset SHALL be honoured mid-operation: in-flight WAIT entries are discarded.
REQ-033 A fill on the first cycle after reset SHALL be ignored and SHALL NOT set resp_err.

Configuration
REQ-034 Macro MSHR_MERGE_EN SHALL enable miss merging.
- Defined: when miss_line equals the address of a PEND or WAIT entry, miss_merged=1 and mshr_wr_idx is that entry's index.
- Defined: a merged miss allocates nothing and is accepted even when mshr_full=1.
- Not defined: no address comparators exist and miss_merged is tied 0.

Structure
REQ-035 The shared cache package SHALL hold:
- the entry-state enumeration and its encoding (FREE=0, PEND=1, WAIT=2, DONE=3);
- the defaults for N_ENTRIES and LINE_BITS.
REQ-036 Sub-module rr_pick SHALL implement the round-robin first-set search; everything else SHALL be flat.

Verification
REQ-037 A bench SHALL cover this fill case.
- Stimulus: a miss with line 0x1234567, ready held 1, fill idx 0 three cycles later.
- Response: mem_req_valid one cycle after the miss, idx 0; mshr_fin pulse with idx 0; entry 0 free one cycle after the pulse.
REQ-038 A bench SHALL cover this full case.
- Stimulus: 8 misses to distinct lines, then a 9th.
- Response: mshr_full=1 and the 9th is not allocated.
- Stimulus: fill idx 5.
- Response: mshr_wr_idx=5 two cycles after the fill.
REQ-039 A bench SHALL cover this backpressure case.
- Stimulus: entries 2, 3 and 6 PEND with ready=0 for 4 cycles, then ready=1.
- Response: request fields stable while stalled; issue order 2, 3, 6.
REQ-040 A bench SHALL cover this error case.
- Stimulus: a fill to a FREE index 4.
- Response: resp_err=1 and no mshr_fin.
REQ-041 A bench SHALL cover this reset case.
- Stimulus: rst=0 asserted while entries 0 and 1 are in WAIT.
- Response: all entries FREE, and a fill to idx 0 after reset sets nothing.
REQ-042 A bench SHALL cover this merge case, with MSHR_MERGE_EN defined.
- Stimulus: a second miss to a line held by WAIT entry 1.
- Response: miss_merged=1, mshr_wr_idx=1 and no new allocation.
